// File: rtl/transpose_pingpong_4x4.sv
// Ping-pong 4x4 transpose: rows fill one bank while columns of the other bank
// stream out; each bank's full flag hands it between the write and read sides.
module transpose_pingpong_4x4 #(
    parameter int DATA_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [4*DATA_WIDTH-1:0] s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [4*DATA_WIDTH-1:0] m_data
);

    logic [DATA_WIDTH-1:0] mem_q [2][4][4];  // [bank][row][col]

    logic [1:0] full_q, full_d;
    logic       wr_bank_q, wr_bank_d;
    logic [1:0] wr_row_q, wr_row_d;
    logic       rd_bank_q, rd_bank_d;
    logic [1:0] rd_col_q, rd_col_d;
    logic       wr_fire, rd_fire;

    assign s_ready = ~full_q[wr_bank_q] & ~reset;
    assign m_valid = full_q[rd_bank_q];
    assign wr_fire = s_valid & s_ready;
    assign rd_fire = m_valid & m_ready;

    // The write side only touches an empty bank and the read side only a full
    // one, so both completions can land in the same cycle without conflict.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        wr_row_d  = wr_row_q;
        rd_bank_d = rd_bank_q;
        rd_col_d  = rd_col_q;
        if (wr_fire) begin
            wr_row_d = wr_row_q + 2'd1;
            if (wr_row_q == 2'd3) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
        if (rd_fire) begin
            rd_col_d = rd_col_q + 2'd1;
            if (rd_col_q == 2'd3) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            wr_row_q  <= 2'd0;
            rd_bank_q <= 1'b0;
            rd_col_q  <= 2'd0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            wr_row_q  <= wr_row_d;
            rd_bank_q <= rd_bank_d;
            rd_col_q  <= rd_col_d;
        end
    end

    // NOTE: storage is not reset; the full flags alone decide when its contents are visible.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int k = 0; k < 4; k++) begin
                mem_q[wr_bank_q][wr_row_q][k] <= s_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        m_data = '0;
        for (int i = 0; i < 4; i++) begin
            m_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_bank_q][i][rd_col_q];
        end
    end

endmodule

// File: tb/tb_transpose_pingpong_4x4.sv
// Self-checking bench for transpose_pingpong_4x4: directed scenarios plus a
// randomized stall run, all compared against a block-level transpose model.
module tb_transpose_pingpong_4x4;

    localparam int W  = 12;
    localparam int DW = 4 * W;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    transpose_pingpong_4x4 #(.DATA_WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
    );

    // Reference model: accepted rows gather into a block; a complete block is
    // transposed into four expected columns. Complete-but-unread blocks
    // occupy banks, so readiness follows from block counts alone.
    logic [DW-1:0] pend_rows[$];
    logic [DW-1:0] exp_cols[$];
    int            blocks_written;
    int            cols_read;

    function automatic int full_blocks();
        return blocks_written - cols_read / 4;
    endfunction

    task automatic model_reset();
        pend_rows.delete();
        exp_cols.delete();
        blocks_written = 0;
        cols_read      = 0;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] dir_row(input int r);
        logic [DW-1:0] v;
        for (int k = 0; k < 4; k++) v[k*W +: W] = W'(r * 16 + k);
        return v;
    endfunction

    function automatic logic [DW-1:0] dir_col(input int c);
        logic [DW-1:0] v;
        for (int i = 0; i < 4; i++) v[i*W +: W] = W'(i * 16 + c);
        return v;
    endfunction

    function automatic logic [DW-1:0] rnd_row();
        return DW'({$urandom(), $urandom()});
    endfunction

    // One clock: check outputs at the falling edge, then advance the model
    // with the handshakes the model says happen on the rising edge.
    task automatic cycle();
        bit exp_sr, exp_mv, wr, rd;
        logic [DW-1:0] col;
        @(negedge clk);
        exp_sr = !reset && full_blocks() < 2;
        exp_mv = !reset && full_blocks() > 0;
        chk("s_ready", DW'(s_ready), DW'(exp_sr));
        chk("m_valid", DW'(m_valid), DW'(exp_mv));
        if (exp_mv && exp_cols.size() > 0) chk("m_data", m_data, exp_cols[0]);
        wr = exp_sr && s_valid;
        rd = exp_mv && m_ready;
        @(posedge clk);
        if (rd) begin
            void'(exp_cols.pop_front());
            cols_read++;
        end
        if (wr) begin
            pend_rows.push_back(s_data);
            if (pend_rows.size() == 4) begin
                for (int c = 0; c < 4; c++) begin
                    for (int i = 0; i < 4; i++) col[i*W +: W] = pend_rows[i][c*W +: W];
                    exp_cols.push_back(col);
                end
                pend_rows.delete();
                blocks_written++;
            end
        end
        #1;
    endtask

    initial begin
        logic [DW-1:0] held;
        logic [DW-1:0] rows_b[4];
        int            base;
        int            sent;
        bit            done;

        reset   = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        s_data  = '0;
        model_reset();
        repeat (2) cycle();
        reset = 1'b0;

        // Single directed block, m_ready held high.
        m_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            s_valid = 1'b1;
            s_data  = dir_row(r);
            cycle();
        end
        s_valid = 1'b0;
        chk("latency_m_valid", DW'(m_valid), DW'(1));
        for (int c = 0; c < 4; c++) begin
            chk("dir_col", m_data, dir_col(c));
            cycle();
        end
        chk("after_block_m_valid", DW'(m_valid), DW'(0));

        // Three blocks back-to-back.
        base = cols_read;
        s_valid = 1'b1;
        m_ready = 1'b1;
        for (int r = 0; r < 12; r++) begin
            s_data = rnd_row();
            chk("stream_s_ready", DW'(s_ready), DW'(1));
            cycle();
        end
        s_valid = 1'b0;
        repeat (6) cycle();
        chk("stream_cols", DW'(cols_read - base), DW'(12));

        // Backpressure: both banks fill, output holds.
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int r = 0; r < 8; r++) begin
            s_data = rnd_row();
            cycle();
        end
        s_data = rnd_row();
        cycle();
        chk("bp_s_ready_low", DW'(s_ready), DW'(0));
        s_valid = 1'b0;
        held = exp_cols[0];
        repeat (3) cycle();
        chk("bp_m_data_stable", m_data, held);
        m_ready = 1'b1;
        repeat (4) cycle();
        chk("bp_s_ready_back", DW'(s_ready), DW'(1));
        repeat (5) cycle();

        // Simultaneous completion of write to bank 1 and read of bank 0.
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int r = 0; r < 4; r++) begin
            s_data = rnd_row();
            cycle();
        end
        for (int r = 0; r < 3; r++) begin
            rows_b[r] = rnd_row();
            s_data    = rows_b[r];
            cycle();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (3) cycle();
        rows_b[3] = rnd_row();
        s_data    = rows_b[3];
        s_valid   = 1'b1;
        cycle();
        s_valid = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) held[i*W +: W] = rows_b[i][0 +: W];
        chk("sim_m_valid", DW'(m_valid), DW'(1));
        chk("sim_s_ready", DW'(s_ready), DW'(1));
        chk("sim_first_col", m_data, held);
        m_ready = 1'b1;
        repeat (5) cycle();

        // Reset after two rows of a block.
        s_valid = 1'b1;
        for (int r = 0; r < 2; r++) begin
            s_data = rnd_row();
            cycle();
        end
        s_valid = 1'b0;
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_m_valid", DW'(m_valid), DW'(0));
        chk("rst_s_ready", DW'(s_ready), DW'(0));
        repeat (2) cycle();
        reset   = 1'b0;
        s_valid = 1'b1;
        for (int r = 0; r < 4; r++) begin
            s_data = rnd_row();
            cycle();
        end
        s_valid = 1'b0;
        repeat (5) cycle();
        chk("rst_cols", DW'(cols_read), DW'(4));

        // Random 50% stalls over 100 blocks.
        base = cols_read;
        sent = 0;
        done = 1'b0;
        for (int t = 0; t < 6000 && !done; t++) begin
            s_valid = (sent < 400) && ($urandom_range(0, 1) == 1);
            s_data  = rnd_row();
            m_ready = ($urandom_range(0, 1) == 1);
            if (s_valid && full_blocks() < 2) sent++;
            cycle();
            done = (cols_read - base) == 400;
        end
        chk("rand_done", DW'(done), DW'(1));
        chk("rand_cols", DW'(cols_read - base), DW'(400));
        s_valid = 1'b0;
        m_ready = 1'b0;
        cycle();
        chk("final_empty", DW'(exp_cols.size()), DW'(0));
        chk("final_m_valid", DW'(m_valid), DW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
